// File: rtl/tile_ctrl_axil_master_if.sv
// rtl/tile_ctrl_axil_master_if.sv - AXI4-Lite control bus bundle with master/slave views
interface tile_ctrl_axil_master_if #(
  parameter int BW       = 32,
  parameter int BWB      = BW / 8,
  parameter int AXI_ADDR = 8
);
  logic [AXI_ADDR-1:0] awaddr;
  logic                awvalid;
  logic                awready;
  logic [BW-1:0]       wdata;
  logic [BWB-1:0]      wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [AXI_ADDR-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [BW-1:0]       rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/tile_ctrl_axil_master.sv
// rtl/tile_ctrl_axil_master.sv - single-outstanding AXI4-Lite initiator for a tile control port (optional abort: TILE_CTRL_AXIL_TIMEOUT_EN)
module tile_ctrl_axil_master #(
  parameter int BW             = 32,
  parameter int BWB            = BW / 8,
  parameter int AXI_ADDR       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_control,
  input  logic                clk_control_rst_high,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_ADDR-1:0] cmd_addr,
  input  logic [BW-1:0]       cmd_wdata,
  input  logic [BWB-1:0]      cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [BW-1:0]       rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  tile_ctrl_axil_master_if.master control_M_AXI
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t              state_q, state_n;
  logic                cmd_ready_n;
  logic                awvalid_q, awvalid_n;
  logic                wvalid_q, wvalid_n;
  logic                bready_q, bready_n;
  logic                arvalid_q, arvalid_n;
  logic                rready_q, rready_n;
  logic                write_q, write_n;
  logic [AXI_ADDR-1:0] addr_q, addr_n;
  logic [BW-1:0]       wdata_q, wdata_n;
  logic [BWB-1:0]      wstrb_q, wstrb_n;
  logic                rsp_valid_n;
  logic                rsp_write_n;
  logic [BW-1:0]       rsp_data_n;
  logic [1:0]          rsp_resp_n;
  logic                rsp_timeout_n;

`ifdef TILE_CTRL_AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          in_wait;
`else
  // The wait budget only matters when the abort logic is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // The same latched address serves both address channels; only one VALID is ever raised.
  assign control_M_AXI.awaddr  = addr_q;
  assign control_M_AXI.araddr  = addr_q;
  assign control_M_AXI.wdata   = wdata_q;
  assign control_M_AXI.wstrb   = wstrb_q;
  assign control_M_AXI.awvalid = awvalid_q;
  assign control_M_AXI.wvalid  = wvalid_q;
  assign control_M_AXI.bready  = bready_q;
  assign control_M_AXI.arvalid = arvalid_q;
  assign control_M_AXI.rready  = rready_q;

  // Next-state and next-output computation; every output is then registered below.
  always_comb begin
    state_n       = state_q;
    cmd_ready_n   = cmd_ready;
    awvalid_n     = awvalid_q;
    wvalid_n      = wvalid_q;
    bready_n      = bready_q;
    arvalid_n     = arvalid_q;
    rready_n      = rready_q;
    write_n       = write_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    wstrb_n       = wstrb_q;
    rsp_valid_n   = rsp_valid;
    rsp_write_n   = rsp_write;
    rsp_data_n    = rsp_data;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;

    case (state_q)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          write_n     = cmd_write;
          addr_n      = cmd_addr;
          wdata_n     = cmd_wdata;
          wstrb_n     = cmd_wstrb;
          if (cmd_write) begin
            state_n   = WR_AW_W;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_AR;
            arvalid_n = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently, in any order.
        if (awvalid_q && control_M_AXI.awready) awvalid_n = 1'b0;
        if (wvalid_q && control_M_AXI.wready)   wvalid_n  = 1'b0;
        if (!awvalid_n && !wvalid_n) begin
          state_n  = WR_B;
          bready_n = 1'b1;
        end
      end
      WR_B: begin
        if (control_M_AXI.bvalid) begin
          state_n       = RESP;
          bready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_write_n   = 1'b1;
          rsp_data_n    = '0;
          rsp_resp_n    = control_M_AXI.bresp;
          rsp_timeout_n = 1'b0;
        end
      end
      RD_AR: begin
        if (control_M_AXI.arready) begin
          state_n   = RD_R;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end
      end
      RD_R: begin
        if (control_M_AXI.rvalid) begin
          state_n       = RESP;
          rready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_write_n   = 1'b0;
          rsp_data_n    = control_M_AXI.rdata;
          rsp_resp_n    = control_M_AXI.rresp;
          rsp_timeout_n = 1'b0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

`ifdef TILE_CTRL_AXIL_TIMEOUT_EN
    in_wait = (state_q == WR_AW_W) || (state_q == WR_B) ||
              (state_q == RD_AR)   || (state_q == RD_R);
    cnt_n = cnt_q;
    if (state_q == IDLE)  cnt_n = '0;
    else if (in_wait)     cnt_n = cnt_q + CW'(1);
    // Budget covers the whole transaction, so moving between wait states does not rescue it.
    if (in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && (state_n != RESP)) begin
      state_n       = RESP;
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_write_n   = write_q;
      rsp_data_n    = '0;
      rsp_resp_n    = 2'b10;
      rsp_timeout_n = 1'b1;
    end
`endif
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) begin
      state_q     <= IDLE;
      cmd_ready   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_n;
      cmd_ready   <= cmd_ready_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      bready_q    <= bready_n;
      arvalid_q   <= arvalid_n;
      rready_q    <= rready_n;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      rsp_valid   <= rsp_valid_n;
      rsp_write   <= rsp_write_n;
      rsp_data    <= rsp_data_n;
      rsp_resp    <= rsp_resp_n;
      rsp_timeout <= rsp_timeout_n;
    end
  end

`ifdef TILE_CTRL_AXIL_TIMEOUT_EN
  // Wait-cycle counter for the abort path.
  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) cnt_q <= '0;
    else                      cnt_q <= cnt_n;
  end
`endif

endmodule

// File: tb/tb_tile_ctrl_axil_master.sv
// tb/tb_tile_ctrl_axil_master.sv - directed self-checking bench for tile_ctrl_axil_master
module tb_tile_ctrl_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  int          n_checks = 0;
  int          n_pass = 0;

  tile_ctrl_axil_master_if #(.BW(32), .AXI_ADDR(8)) axi ();

  tile_ctrl_axil_master #(.BW(32), .AXI_ADDR(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_control(clk), .clk_control_rst_high(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .control_M_AXI(axi.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for exactly one edge.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    axi.awready = 0; axi.wready = 0; axi.bresp = 0; axi.bvalid = 0;
    axi.arready = 0; axi.rdata = 0; axi.rresp = 0; axi.rvalid = 0;
    step(); step();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("rst_valids", {59'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 64'd0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_data}, 64'd0);
    rst = 1'b0;
    step();
    chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

    // Write, slave always ready: AW/W at cycle 1, BREADY cycle 2, rsp_valid cycle 3.
    axi.awready = 1; axi.wready = 1;
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    chk("w1_aw_w_valid", {62'd0, axi.awvalid, axi.wvalid}, 64'd3);
    chk("w1_awaddr", {56'd0, axi.awaddr}, 64'h10);
    chk("w1_wdata_strb", {28'd0, axi.wstrb, axi.wdata}, {28'd0, 4'hF, 32'hDEADBEEF});
    chk("w1_cmd_ready_busy", {63'd0, cmd_ready}, 64'd0);
    step();
    chk("w1_bready", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd1);
    axi.bvalid = 1; axi.bresp = 2'b00;
    step();
    axi.bvalid = 0;
    chk("w1_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_data}, {5'b11000, 32'd0});
    chk("w1_bready_low", {63'd0, axi.bready}, 64'd0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("w1_back_idle", {62'd0, rsp_valid, cmd_ready}, 64'd1);

    // Read with ARREADY held off for 3 cycles: ARVALID/ARADDR held 4 cycles.
    axi.awready = 0; axi.wready = 0;
    issue(1'b0, 8'h04, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      chk("r1_arvalid_hold", {55'd0, axi.arvalid, axi.araddr}, {55'd0, 1'b1, 8'h04});
      if (i == 3) axi.arready = 1;
      step();
    end
    axi.arready = 0;
    chk("r1_rready", {62'd0, axi.arvalid, axi.rready}, 64'd1);
    axi.rvalid = 1; axi.rdata = 32'h12345678; axi.rresp = 2'b00;
    step();
    axi.rvalid = 0;
    chk("r1_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_data}, {5'b10000, 32'h12345678});
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("r1_done", {63'd0, rsp_valid}, 64'd0);

    // Write: WREADY two cycles ahead of AWREADY, then the reverse order.
    for (int ord = 0; ord < 2; ord++) begin
      issue(1'b1, 8'h20, 32'hA5A5_0000 + ord, 4'h3);
      if (ord == 0) axi.wready = 1; else axi.awready = 1;
      step();
      axi.wready = 0; axi.awready = 0;
      chk("split_first_drop", {62'd0, axi.awvalid, axi.wvalid}, (ord == 0) ? 64'd2 : 64'd1);
      step();
      chk("split_still_held", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, (ord == 0) ? 64'd4 : 64'd2);
      if (ord == 0) axi.awready = 1; else axi.wready = 1;
      step();
      axi.wready = 0; axi.awready = 0;
      chk("split_bready", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd1);
      axi.bvalid = 1; axi.bresp = 2'b10;
      step();
      axi.bvalid = 0;
      chk("split_rsp", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, axi.bready}, {5'b11010, 1'b0});
      step();
      chk("split_one_bready", {62'd0, axi.bready, rsp_valid}, 64'd1);
      rsp_ready = 1;
      step();
      chk("split_one_rsp", {62'd0, rsp_valid, axi.bready}, 64'd0);
      rsp_ready = 0;
    end

    // Read returning DECERR with rsp_ready stalled 5 cycles; a busy-time command is ignored.
    axi.arready = 1;
    issue(1'b0, 8'h0C, 32'h0, 4'h0);
    step();
    axi.arready = 0;
    axi.rvalid = 1; axi.rdata = 32'hCAFEF00D; axi.rresp = 2'b11;
    step();
    axi.rvalid = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp", {rsp_valid, rsp_write, cmd_ready, rsp_resp, rsp_data}, {5'b10011, 32'hCAFEF00D});
      step();
    end
    rsp_ready = 1;
    step();
    cmd_valid = 0;
    chk("stall_done", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    step();
    chk("busy_cmd_ignored", {54'd0, axi.awvalid, axi.arvalid, axi.araddr}, {54'd0, 2'b00, 8'h0C});
    rsp_ready = 0;

    // Reset while waiting in WR_B, then a read completes normally.
    axi.awready = 1; axi.wready = 1;
    issue(1'b1, 8'h30, 32'h11112222, 4'hF);
    step();
    chk("pre_rst_bready", {63'd0, axi.bready}, 64'd1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_outputs", {55'd0, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                            rsp_valid, cmd_ready, axi.awaddr == 8'h0}, 64'd1);
    axi.bvalid = 1;
    step();
    axi.bvalid = 0;
    chk("post_rst_no_rsp", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    axi.awready = 0; axi.wready = 0; axi.arready = 1;
    issue(1'b0, 8'h08, 32'h0, 4'h0);
    step();
    axi.arready = 0;
    axi.rvalid = 1; axi.rdata = 32'h0A0B0C0D; axi.rresp = 2'b00;
    step();
    axi.rvalid = 0;
    chk("post_rst_read", {rsp_valid, rsp_write, rsp_timeout, rsp_resp, rsp_data}, {5'b10000, 32'h0A0B0C0D});
    rsp_ready = 1;
    step();
    rsp_ready = 0;

`ifdef TILE_CTRL_AXIL_TIMEOUT_EN
    // Slave never returns BVALID: abort after 16 wait cycles.
    axi.awready = 1; axi.wready = 1;
    issue(1'b1, 8'h40, 32'h5, 4'hF);
    for (int i = 0; i < 16; i++) begin
      chk("to_wait", {63'd0, rsp_valid}, 64'd0);
      step();
    end
    chk("to_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_data}, {4'b1110, 32'd0});
    chk("to_bready_low", {63'd0, axi.bready}, 64'd0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    axi.awready = 0; axi.wready = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_ctrl_axil_master.md
Name: tile_ctrl_axil_master

Overview:
- AXI4-Lite initiator that drives a tile's control_S_AXI slave port: register writes for configuration and register reads for status.
- Accepts single-beat commands over a valid/ready command port and returns one response per command over a valid/ready response port.
- Sits in the host/NoC control path in the clk_control domain, one instance per tile control port.
- Exactly one transaction is outstanding at any time.

Parameters:
- BW, 32, control data width in bits.
- BWB, BW/8, write strobe width in bits.
- AXI_ADDR, 8, control address width in bits.
- TIMEOUT_CYCLES, 1024, number of cycles spent waiting on the slave before abort. Used only with the optional feature.

Ports:
- clk_control  in  1  control clock
- clk_control_rst_high  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AXI_ADDR  register address
- cmd_wdata  in  BW  write data
- cmd_wstrb  in  BWB  write strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_write  out  1  echo of cmd_write
- rsp_data  out  BW  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  transaction aborted by timeout
- control_M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  AXI_ADDR/1/1  write address channel
- control_M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  BW/BWB/1/1  write data channel
- control_M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
- control_M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  AXI_ADDR/1/1  read address channel
- control_M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  BW/2/1/1  read data channel

Behaviour:
- One clock, clk_control. Reset clk_control_rst_high is synchronous and active-high.
- While reset is high and on the first edge after it: all VALID/READY outputs 0, cmd_ready 0, rsp_valid 0, rsp_* 0, address/data outputs 0. FSM enters IDLE on the first edge with reset low.
- All outputs are registered. No VALID output depends combinationally on any READY input.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On cmd_valid&&cmd_ready, latch cmd_write, cmd_addr, cmd_wdata, cmd_wstrb.
  - Go to WR_AW_W if write, RD_AR if read.
- WR_AW_W:
  - AWVALID and WVALID are asserted together on the cycle after acceptance.
  - Each VALID is held, with stable payload, until its own READY is seen; then it drops independently.
  - AWREADY and WREADY may arrive in either order or in the same cycle.
  - Go to WR_B once both handshakes are complete.
- WR_B: BREADY=1. On BVALID, capture BRESP, set rsp_data=0, rsp_write=1, go to RESP.
- RD_AR: ARVALID held until ARREADY, then go to RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA/RRESP, set rsp_write=0, go to RESP.
- RESP:
  - rsp_valid=1 with stable payload until rsp_ready.
  - Return to IDLE on the handshake edge. cmd_ready=1 on the following cycle, so back-to-back commands are spaced by at least one idle cycle.
- Minimum latency with a slave that is always ready:
  - Write: command accepted cycle 0; AW/W valid cycle 1; BREADY cycle 2; rsp_valid cycle 3.
  - Read: command accepted cycle 0; ARVALID cycle 1; RREADY cycle 2; rsp_valid cycle 3.
- Error responses (SLVERR/DECERR) are passed through unmodified. They are not retried.
- cmd_valid while busy: ignored. cmd_ready=0, nothing is latched.
- Reset asserted mid-transaction: the transaction is discarded, all outputs return to reset values at that edge, and no response is produced.
- rsp_ready held high in IDLE has no effect.

Optional Feature:
- Macro: TILE_CTRL_AXIL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WR_AW_W or RD_AR and increments every cycle spent in WR_AW_W, WR_B, RD_AR or RD_R.
  - When it reaches TIMEOUT_CYCLES-1 without completion, all AXI VALID/READY outputs drop on the next edge.
  - The FSM goes to RESP with rsp_resp=2'b10, rsp_timeout=1, rsp_data=0.
  - A late slave response after abort is ignored, because the READY outputs are low.
- Undefined: no counter is built, the FSM waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Write cmd addr=8'h10 data=32'hDEADBEEF strb=4'hF, slave always ready, BRESP=0 -> AW/W valid cycle 1, rsp_valid cycle 3, rsp_resp=0, rsp_write=1, rsp_data=0.
- Read addr=8'h04, ARREADY delayed 3 cycles, RDATA=32'h12345678 -> ARVALID held with ARADDR stable for 4 cycles; rsp_data=32'h12345678, rsp_write=0.
- Write with WREADY 2 cycles before AWREADY (and repeat with the reverse order) -> WVALID drops first, AWVALID stays, exactly one BREADY phase, one response.
- Read returning RRESP=2'b11 with rsp_ready held low 5 cycles -> rsp_valid and payload stable for 5 cycles, rsp_resp=2'b11, cmd_ready=0 throughout.
- Reset pulsed while in WR_B -> next cycle all VALID/READY=0, rsp_valid=0; a new read then completes normally.
- With TILE_CTRL_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts BVALID -> abort after 16 wait cycles, rsp_resp=2'b10, rsp_timeout=1.
